recirc_retorno: RTL and testbench

- Return-path end of the recirculation interface: captures the four recirculated lanes (probador_in0..3 / probador_valid0..3) qualified by IDL.
- Buffers each lane in its own small FIFO and re-serialises the words round-robin onto one 8-bit stream with a valid/ready handshake and a lane tag.
- Sits after the recirculation stage and feeds the downstream consumer or checker.

---
 rtl/recirc_pkg.sv | 7 +
 rtl/recirc_retorno_if.sv | 31 +++
 rtl/recirc_fifo.sv | 37 +++
 rtl/recirc_retorno.sv | 65 ++++++
 tb/tb_recirc_retorno.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/recirc_pkg.sv
// recirc_pkg: shared lane count, default widths and lane id type for the recirculation return path
package recirc_pkg;
  localparam int LANES = 4;
  localparam int DATA_W = 8;
  localparam int FIFO_DEPTH = 4;
  typedef logic [1:0] lane_id_t;
endpackage

// File: rtl/recirc_retorno_if.sv
// recirc_retorno_if: lane capture inputs and serialised output stream; drop_count exists only with RECIRC_DROP_CNT_EN
interface recirc_retorno_if import recirc_pkg::*; #(parameter int DATA_W = recirc_pkg::DATA_W);
  logic IDL;
  logic probador_valid0, probador_valid1, probador_valid2, probador_valid3;
  logic [DATA_W-1:0] probador_in0, probador_in1, probador_in2, probador_in3;
  logic out_ready;
  logic [DATA_W-1:0] data_out;
  logic valid_out;
  lane_id_t lane_out;
  logic [LANES-1:0] fifo_full;
  logic overflow;
`ifdef RECIRC_DROP_CNT_EN
  logic [7:0] drop_count;
`endif
  modport master (
`ifdef RECIRC_DROP_CNT_EN
    input drop_count,
`endif
    output IDL, probador_valid0, probador_valid1, probador_valid2, probador_valid3,
    output probador_in0, probador_in1, probador_in2, probador_in3, out_ready,
    input data_out, valid_out, lane_out, fifo_full, overflow
  );
  modport slave (
`ifdef RECIRC_DROP_CNT_EN
    output drop_count,
`endif
    input IDL, probador_valid0, probador_valid1, probador_valid2, probador_valid3,
    input probador_in0, probador_in1, probador_in2, probador_in3, out_ready,
    output data_out, valid_out, lane_out, fifo_full, overflow
  );
endinterface

// File: rtl/recirc_fifo.sv
// recirc_fifo: single-clock FIFO; a push into a full FIFO is accepted only when it is popped in the same cycle
module recirc_fifo import recirc_pkg::*; #(
  parameter int W = DATA_W,
  parameter int D = FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(D);
  logic [W-1:0] mem [D];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic wr, rd;
  assign rd = pop && !empty;
  assign wr = push && (!full || rd);
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(D);
  assign dout = mem[rp];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
endmodule

// File: rtl/recirc_retorno.sv
// recirc_retorno: buffers four recirculated lanes and re-serialises them round-robin; RECIRC_DROP_CNT_EN adds drop_count
module recirc_retorno import recirc_pkg::*; #(
  parameter int DATA_W = recirc_pkg::DATA_W,
  parameter int FIFO_DEPTH = recirc_pkg::FIFO_DEPTH
) (
  input logic clk,
  input logic reset,
  recirc_retorno_if.slave bus
);
  logic [DATA_W-1:0] din [LANES];
  logic [DATA_W-1:0] dout [LANES];
  logic [LANES-1:0] push, pop, empty, full, drop;
  lane_id_t rr_ptr, sel;
  logic any, load_ok;
  assign din[0] = bus.probador_in0;
  assign din[1] = bus.probador_in1;
  assign din[2] = bus.probador_in2;
  assign din[3] = bus.probador_in3;
  assign push = {bus.probador_valid3, bus.probador_valid2, bus.probador_valid1, bus.probador_valid0} & {LANES{bus.IDL}};
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    recirc_fifo #(.W(DATA_W), .D(FIFO_DEPTH)) u_fifo (
      .clk(clk), .reset(reset), .push(push[i]), .pop(pop[i]),
      .din(din[i]), .dout(dout[i]), .empty(empty[i]), .full(full[i])
    );
  end
  // descending scan so the lane closest to rr_ptr wins
  always_comb begin
    sel = rr_ptr;
    any = 1'b0;
    for (int k = LANES - 1; k >= 0; k--)
      if (!empty[lane_id_t'(int'(rr_ptr) + k)]) begin
        sel = lane_id_t'(int'(rr_ptr) + k);
        any = 1'b1;
      end
  end
  assign load_ok = !bus.valid_out || bus.out_ready;
  assign pop = (load_ok && any) ? LANES'(1) << sel : '0;
  assign drop = push & full & ~pop;
  assign bus.fifo_full = full;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bus.data_out <= '0;
      bus.valid_out <= 1'b0;
      bus.lane_out <= '0;
      bus.overflow <= 1'b0;
      rr_ptr <= '0;
    end else begin
      if (load_ok) begin
        bus.valid_out <= any;
        if (any) begin
          bus.data_out <= dout[sel];
          bus.lane_out <= sel;
          rr_ptr <= sel + 1'b1;
        end
      end
      if (|drop) bus.overflow <= 1'b1;
    end
`ifdef RECIRC_DROP_CNT_EN
  logic [8:0] drop_sum;
  assign drop_sum = 9'(bus.drop_count) + 9'($countones(drop));
  always_ff @(posedge clk or posedge reset)
    if (reset) bus.drop_count <= '0;
    else bus.drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
`endif
endmodule

// File: tb/tb_recirc_retorno.sv
// tb_recirc_retorno: directed bench for recirc_retorno; also checks drop_count when RECIRC_DROP_CNT_EN is defined
module tb_recirc_retorno;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  recirc_retorno_if #(.DATA_W(8)) bus ();
  recirc_retorno #(.DATA_W(8), .FIFO_DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic out(input string tag, input logic [7:0] d, input logic [1:0] l);
    chk({tag, "_valid"}, 32'(bus.valid_out), 32'd1);
    chk({tag, "_data"}, 32'(bus.data_out), 32'(d));
    chk({tag, "_lane"}, 32'(bus.lane_out), 32'(l));
  endtask
  task automatic lanes(input logic i, input logic [3:0] v);
    bus.IDL = i;
    {bus.probador_valid3, bus.probador_valid2, bus.probador_valid1, bus.probador_valid0} = v;
  endtask
  initial begin
    lanes(1'b0, 4'b0000);
    bus.probador_in0 = 8'h00;
    bus.probador_in1 = 8'h00;
    bus.probador_in2 = 8'h00;
    bus.probador_in3 = 8'h00;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(bus.valid_out), 32'd0);
    chk("rst_data", 32'(bus.data_out), 32'd0);
    chk("rst_lane", 32'(bus.lane_out), 32'd0);
    chk("rst_full", 32'(bus.fifo_full), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    // IDL low: valids must be ignored
    reset = 1'b0;
    lanes(1'b0, 4'b1111);
    bus.probador_in0 = 8'h11;
    bus.probador_in1 = 8'h22;
    bus.probador_in2 = 8'h33;
    bus.probador_in3 = 8'h44;
    bus.out_ready = 1'b1;
    step();
    step();
    chk("idle_valid", 32'(bus.valid_out), 32'd0);
    chk("idle_full", 32'(bus.fifo_full), 32'd0);
    chk("idle_ovf", 32'(bus.overflow), 32'd0);
    bus.IDL = 1'b1;
    step();
    chk("lat_valid", 32'(bus.valid_out), 32'd0);
    lanes(1'b0, 4'b0000);
    step(); out("rr0", 8'h11, 2'd0);
    step(); out("rr1", 8'h22, 2'd1);
    step(); out("rr2", 8'h33, 2'd2);
    step(); out("rr3", 8'h44, 2'd3);
    step();
    chk("rr_done_valid", 32'(bus.valid_out), 32'd0);
    chk("rr_done_data", 32'(bus.data_out), 32'h44);
    // hold under backpressure
    bus.out_ready = 1'b0;
    lanes(1'b1, 4'b0010);
    bus.probador_in1 = 8'h55;
    step();
    chk("hold_pre_valid", 32'(bus.valid_out), 32'd0);
    bus.probador_in1 = 8'h66;
    step();
    lanes(1'b0, 4'b0000);
    for (int n = 0; n < 5; n++) begin
      step();
      out("hold", 8'h55, 2'd1);
    end
    bus.out_ready = 1'b1;
    step(); out("hold_next", 8'h66, 2'd1);
    step();
    chk("hold_done", 32'(bus.valid_out), 32'd0);
    // lane 0 overflow behind a held lane-3 word
    bus.out_ready = 1'b0;
    lanes(1'b1, 4'b1000);
    bus.probador_in3 = 8'h77;
    step();
    lanes(1'b1, 4'b0001);
    bus.probador_in0 = 8'h99; step();
    out("ovf_hold", 8'h77, 2'd3);
    bus.probador_in0 = 8'hAA; step();
    bus.probador_in0 = 8'hBB; step();
    bus.probador_in0 = 8'hCC; step();
    chk("ovf_full", 32'(bus.fifo_full), 32'h1);
    chk("ovf_pre", 32'(bus.overflow), 32'd0);
    bus.probador_in0 = 8'hDD; step();
    chk("ovf_set", 32'(bus.overflow), 32'd1);
    chk("ovf_full2", 32'(bus.fifo_full), 32'h1);
    out("ovf_hold2", 8'h77, 2'd3);
`ifdef RECIRC_DROP_CNT_EN
    chk("drop_cnt1", 32'(bus.drop_count), 32'd1);
`endif
    lanes(1'b0, 4'b0000);
    bus.out_ready = 1'b1;
    step(); out("drain0", 8'h99, 2'd0);
    chk("drain_full", 32'(bus.fifo_full), 32'h0);
    step(); out("drain1", 8'hAA, 2'd0);
    step(); out("drain2", 8'hBB, 2'd0);
    step(); out("drain3", 8'hCC, 2'd0);
    step();
    chk("drain_done", 32'(bus.valid_out), 32'd0);
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2_ovf", 32'(bus.overflow), 32'd0);
    // full lane 2 pushed and popped in the same cycle
    bus.out_ready = 1'b0;
    lanes(1'b1, 4'b0100);
    for (int n = 1; n <= 5; n++) begin
      bus.probador_in2 = 8'(n);
      step();
    end
    chk("f2_full", 32'(bus.fifo_full), 32'h4);
    out("f2_hold", 8'h01, 2'd2);
    bus.out_ready = 1'b1;
    bus.probador_in2 = 8'hEE;
    step();
    out("f2_pop", 8'h02, 2'd2);
    chk("f2_full_kept", 32'(bus.fifo_full), 32'h4);
    chk("f2_ovf", 32'(bus.overflow), 32'd0);
    lanes(1'b0, 4'b0000);
    step(); out("f2_d3", 8'h03, 2'd2);
    chk("f2_notfull", 32'(bus.fifo_full), 32'h0);
    step(); out("f2_d4", 8'h04, 2'd2);
    step(); out("f2_d5", 8'h05, 2'd2);
    step(); out("f2_dee", 8'hEE, 2'd2);
    step();
    chk("f2_done", 32'(bus.valid_out), 32'd0);
    // reset with words buffered and held
    bus.out_ready = 1'b0;
    lanes(1'b1, 4'b1010);
    bus.probador_in1 = 8'h61;
    bus.probador_in3 = 8'h63;
    step();
    bus.probador_in1 = 8'h62;
    bus.probador_in3 = 8'h64;
    step();
    lanes(1'b1, 4'b1000);
    bus.probador_in3 = 8'h65;
    step();
    out("mid_hold", 8'h63, 2'd3);
    lanes(1'b0, 4'b0000);
    reset = 1'b1;
    #1;
    chk("async_valid", 32'(bus.valid_out), 32'd0);
    chk("async_data", 32'(bus.data_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step();
      chk("post_rst_valid", 32'(bus.valid_out), 32'd0);
    end
    chk("post_rst_full", 32'(bus.fifo_full), 32'd0);
`ifdef RECIRC_DROP_CNT_EN
    chk("drop_cnt_rst", 32'(bus.drop_count), 32'd0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
